// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: instruction and operands in, hazard/forwarding
// inputs, and the latched ALU operation and stage controls out.
interface id_ex_stage_if;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_y;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wdata;
  logic        stall_out;
  logic        out_valid;
  logic [2:0]  alu_s;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  dest;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic [31:0] store_data;
  logic        is_beq;
  logic        illegal;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush,
           exmem_regwrite, exmem_rd, exmem_y,
           memwb_regwrite, memwb_rd, memwb_wdata,
    input  stall_out, out_valid, alu_s, alu_a, alu_b, dest,
           regwrite, memread, memwrite, store_data, is_beq, illegal
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush,
           exmem_regwrite, exmem_rd, exmem_y,
           memwb_regwrite, memwb_rd, memwb_wdata,
    output stall_out, out_valid, alu_s, alu_a, alu_b, dest,
           regwrite, memread, memwrite, store_data, is_beq, illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS ID/EX pipeline stage: decode, load-use stall detection, ID/EX
// register and EX-side operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] latched,
    input logic        erw,
    input logic [4:0]  erd,
    input logic [31:0] ey,
    input logic        mrw,
    input logic [4:0]  mrd,
    input logic [31:0] mwd
  );
    logic [31:0] val;
    if (erw && (erd != 5'd0) && (erd == idx)) begin
      val = ey;
    end else if (mrw && (mrd != 5'd0) && (mrd == idx)) begin
      val = mwd;
    end else begin
      val = latched;
    end
    return val;
  endfunction

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_idx_s;
  logic [4:0]  rt_idx_s;
  logic [4:0]  rd_idx_s;
  logic        dec_ok_s;
  logic [2:0]  dec_alu_s;
  logic [4:0]  dec_dest_s;
  logic        dec_rw_s;
  logic        dec_mr_s;
  logic        dec_mw_s;
  logic        dec_beq_s;
  logic        dec_use_imm_s;
  logic        dec_sext_s;
  logic        dec_reads_rt_s;
  logic [31:0] imm_s;
  logic        load_use_s;
  logic        stall_s;
  logic        take_s;
  logic        bad_s;
  logic [31:0] fwd_rs_s;
  logic [31:0] fwd_rt_s;

  logic        valid_r;
  logic        illegal_r;
  logic        regwrite_r;
  logic        memread_r;
  logic        memwrite_r;
  logic        is_beq_r;
  logic [2:0]  alu_r;
  logic [4:0]  dest_r;
  logic [4:0]  rs_idx_r;
  logic [4:0]  rt_idx_r;
  logic [31:0] rs_data_r;
  logic [31:0] rt_data_r;
  logic [31:0] imm_r;
  logic        use_imm_r;

  assign op_s     = bus.instr[31:26];
  assign rs_idx_s = bus.instr[25:21];
  assign rt_idx_s = bus.instr[20:16];
  assign rd_idx_s = bus.instr[15:11];
  assign funct_s  = bus.instr[5:0];

  // Instruction decode into ALU op, destination and stage controls.
  always_comb begin
    dec_ok_s       = 1'b0;
    dec_alu_s      = ALU_ADD;
    dec_dest_s     = 5'd0;
    dec_rw_s       = 1'b0;
    dec_mr_s       = 1'b0;
    dec_mw_s       = 1'b0;
    dec_beq_s      = 1'b0;
    dec_use_imm_s  = 1'b1;
    dec_sext_s     = 1'b1;
    dec_reads_rt_s = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        dec_use_imm_s  = 1'b0;
        dec_reads_rt_s = 1'b1;
        dec_dest_s     = rd_idx_s;
        dec_rw_s       = 1'b1;
        dec_ok_s       = 1'b1;
        case (funct_s)
          FN_ADD:  dec_alu_s = ALU_ADD;
          FN_SUB:  dec_alu_s = ALU_SUB;
          FN_AND:  dec_alu_s = ALU_AND;
          FN_OR:   dec_alu_s = ALU_OR;
          FN_XOR:  dec_alu_s = ALU_XOR;
          FN_NOR:  dec_alu_s = ALU_NOR;
          FN_SLT:  dec_alu_s = ALU_SLT;
          default: begin
            dec_ok_s = 1'b0;
            dec_rw_s = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_ADD; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
      end
      OP_SLTI: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_SLT; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
      end
      OP_ANDI: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_AND; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
        dec_sext_s = 1'b0;
      end
      OP_ORI: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_OR; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
        dec_sext_s = 1'b0;
      end
      OP_XORI: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_XOR; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
        dec_sext_s = 1'b0;
      end
      OP_LW: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_ADD; dec_dest_s = rt_idx_s; dec_rw_s = 1'b1;
        dec_mr_s = 1'b1;
      end
      OP_SW: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_ADD; dec_mw_s = 1'b1; dec_reads_rt_s = 1'b1;
      end
      OP_BEQ: begin
        dec_ok_s = 1'b1; dec_alu_s = ALU_SUB; dec_beq_s = 1'b1; dec_use_imm_s = 1'b0;
        dec_reads_rt_s = 1'b1;
      end
      default: begin
        dec_ok_s = 1'b0;
      end
    endcase
  end

  // Immediate extension, hazard detection and latch-source selection.
  always_comb begin
    if (dec_sext_s) begin
      imm_s = {{16{bus.instr[15]}}, bus.instr[15:0]};
    end else begin
      imm_s = {16'h0000, bus.instr[15:0]};
    end
    load_use_s = valid_r && memread_r && (dest_r != 5'd0) && bus.in_valid &&
                 ((rs_idx_s == dest_r) || (dec_reads_rt_s && (rt_idx_s == dest_r)));
    stall_s = !rst && !bus.flush && load_use_s;
    take_s  = bus.in_valid && !bus.flush && !stall_s && dec_ok_s;
    bad_s   = bus.in_valid && !bus.flush && !stall_s && !dec_ok_s;
  end

  // ID/EX pipeline register; anything not taken becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      illegal_r  <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      is_beq_r   <= 1'b0;
      alu_r      <= ALU_ADD;
      dest_r     <= 5'd0;
      rs_idx_r   <= 5'd0;
      rt_idx_r   <= 5'd0;
      rs_data_r  <= 32'h0000_0000;
      rt_data_r  <= 32'h0000_0000;
      imm_r      <= 32'h0000_0000;
      use_imm_r  <= 1'b0;
    end else begin
      rs_idx_r  <= rs_idx_s;
      rt_idx_r  <= rt_idx_s;
      rs_data_r <= bus.rs_data;
      rt_data_r <= bus.rt_data;
      imm_r     <= imm_s;
      use_imm_r <= dec_use_imm_s;
      if (take_s) begin
        valid_r    <= 1'b1;
        illegal_r  <= 1'b0;
        regwrite_r <= dec_rw_s && (dec_dest_s != 5'd0);
        memread_r  <= dec_mr_s;
        memwrite_r <= dec_mw_s;
        is_beq_r   <= dec_beq_s;
        alu_r      <= dec_alu_s;
        dest_r     <= dec_dest_s;
      end else begin
        valid_r    <= 1'b0;
        illegal_r  <= bad_s;
        regwrite_r <= 1'b0;
        memread_r  <= 1'b0;
        memwrite_r <= 1'b0;
        is_beq_r   <= 1'b0;
        alu_r      <= ALU_ADD;
        dest_r     <= 5'd0;
      end
    end
  end

  // EX-side operand forwarding on the latched register indices.
  always_comb begin
    fwd_rs_s = fwd_sel(rs_idx_r, rs_data_r, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_y,
                       bus.memwb_regwrite, bus.memwb_rd, bus.memwb_wdata);
    fwd_rt_s = fwd_sel(rt_idx_r, rt_data_r, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_y,
                       bus.memwb_regwrite, bus.memwb_rd, bus.memwb_wdata);
  end

  assign bus.stall_out  = stall_s;
  assign bus.out_valid  = valid_r;
  assign bus.alu_s      = alu_r;
  assign bus.alu_a      = fwd_rs_s;
  assign bus.alu_b      = use_imm_r ? imm_r : fwd_rt_s;
  assign bus.store_data = fwd_rt_s;
  assign bus.dest       = dest_r;
  assign bus.regwrite   = regwrite_r;
  assign bus.memread    = memread_r;
  assign bus.memwrite   = memwrite_r;
  assign bus.is_beq     = is_beq_r;
  assign bus.illegal    = illegal_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected stage outputs are queued when an
// instruction is driven and compared after the latching edge.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        ill;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        beq;
    logic [2:0]  alu;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
  } obs_t;

  obs_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Snapshot of the outputs; fields that are don't-care for a bubble read as 0.
  function automatic obs_t cap();
    obs_t o;
    o.valid = bus.out_valid;
    o.ill   = bus.illegal;
    o.rw    = bus.regwrite;
    o.mr    = bus.memread;
    o.mw    = bus.memwrite;
    o.beq   = bus.is_beq;
    o.alu   = bus.out_valid ? bus.alu_s : 3'd0;
    o.dest  = bus.regwrite ? bus.dest : 5'd0;
    o.a     = bus.out_valid ? bus.alu_a : 32'h0;
    o.b     = bus.out_valid ? bus.alu_b : 32'h0;
    o.sd    = bus.out_valid ? bus.store_data : 32'h0;
    return o;
  endfunction

  function automatic obs_t mk(input logic v, il, rw, mr, mw, bq, input logic [2:0] al,
                              input logic [4:0] d, input logic [31:0] a, b, sd);
    obs_t o;
    o.valid = v; o.ill = il; o.rw = rw; o.mr = mr; o.mw = mw; o.beq = bq;
    o.alu = al; o.dest = d; o.a = a; o.b = b; o.sd = sd;
    return o;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, rsd, rtd, input logic v, fl);
    bus.instr = ins; bus.rs_data = rsd; bus.rt_data = rtd;
    bus.in_valid = v; bus.flush = fl;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] ey,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mwd);
    bus.exmem_regwrite = erw; bus.exmem_rd = erd; bus.exmem_y = ey;
    bus.memwb_regwrite = mrw; bus.memwb_rd = mrd; bus.memwb_wdata = mwd;
  endtask

  obs_t bubble;
  assign bubble = '0;

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h5, 32'h7, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    got = cap();
    nvec++;
    if (got !== bubble) begin
      nerr++; $display("FAIL reset_outputs got=%h exp=%h", got, bubble);
    end
    nvec++;
    if ({bus.dest, bus.alu_s, bus.alu_a, bus.stall_out, bus.illegal} !== 42'd0) begin
      nerr++;
      $display("FAIL reset_raw dest=%0d alu_s=%0d alu_a=%h stall=%b illegal=%b exp all 0",
               bus.dest, bus.alu_s, bus.alu_a, bus.stall_out, bus.illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] ins [16];
    obs_t        ex  [16];
    obs_t        got;
    obs_t        e;
    ins[0]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);  ex[0]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,5'd3,32'd5,32'd7,32'd7);
    ins[1]  = rtype(5'd1, 5'd2, 5'd4, 6'h22);  ex[1]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd1,5'd4,32'd5,32'd7,32'd7);
    ins[2]  = rtype(5'd1, 5'd2, 5'd5, 6'h24);  ex[2]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,5'd5,32'd5,32'd7,32'd7);
    ins[3]  = rtype(5'd1, 5'd2, 5'd6, 6'h25);  ex[3]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd3,5'd6,32'd5,32'd7,32'd7);
    ins[4]  = rtype(5'd1, 5'd2, 5'd7, 6'h26);  ex[4]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd4,5'd7,32'd5,32'd7,32'd7);
    ins[5]  = rtype(5'd1, 5'd2, 5'd8, 6'h27);  ex[5]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd5,5'd8,32'd5,32'd7,32'd7);
    ins[6]  = rtype(5'd1, 5'd2, 5'd10, 6'h2A); ex[6]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd6,5'd10,32'd5,32'd7,32'd7);
    ins[7]  = rtype(5'd1, 5'd2, 5'd0, 6'h20);  ex[7]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,5'd0,32'd5,32'd7,32'd7);
    ins[8]  = itype(6'h0C, 5'd1, 5'd4, 16'h8000); ex[8]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd2,5'd4,32'd5,32'h0000_8000,32'd7);
    ins[9]  = itype(6'h08, 5'd1, 5'd4, 16'h8000); ex[9]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,5'd4,32'd5,32'hFFFF_8000,32'd7);
    ins[10] = itype(6'h0A, 5'd1, 5'd4, 16'hFFFF); ex[10] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd6,5'd4,32'd5,32'hFFFF_FFFF,32'd7);
    ins[11] = itype(6'h0D, 5'd1, 5'd4, 16'h1234); ex[11] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd3,5'd4,32'd5,32'h0000_1234,32'd7);
    ins[12] = itype(6'h0E, 5'd1, 5'd4, 16'hFFFF); ex[12] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd4,5'd4,32'd5,32'h0000_FFFF,32'd7);
    ins[13] = itype(6'h23, 5'd1, 5'd9, 16'h0010); ex[13] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,5'd9,32'd5,32'h0000_0010,32'd7);
    ins[14] = itype(6'h2B, 5'd1, 5'd2, 16'hFFFC); ex[14] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,3'd0,5'd0,32'd5,32'hFFFF_FFFC,32'd7);
    ins[15] = itype(6'h04, 5'd1, 5'd2, 16'h0003); ex[15] = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,5'd0,32'd5,32'd7,32'd7);
    for (int i = 0; i < 16; i++) begin
      drive(ins[i], 32'd5, 32'd7, 1'b1, 1'b0);
      exp_q.push_back(ex[i]);
      #1;
      nvec++;
      if (bus.stall_out !== 1'b0) begin
        nerr++; $display("FAIL decode_nostall[%0d] got=%b exp=0", i, bus.stall_out);
      end
      @(posedge clk); #1;
      got = cap();
      e = exp_q.pop_front();
      nvec++;
      if (got !== e) begin
        nerr++; $display("FAIL decode[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_load_use();
    obs_t got;
    obs_t e;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'd3, 32'd0, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,5'd2,32'd3,32'd0,32'd0));
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL lu_lw got=%h exp=%h", got, e); end
    drive(rtype(5'd2, 5'd2, 5'd5, 6'h20), 32'hAA, 32'hAA, 1'b1, 1'b0);
    #1; nvec++;
    if (bus.stall_out !== 1'b1) begin nerr++; $display("FAIL lu_stall got=%b exp=1", bus.stall_out); end
    exp_q.push_back(bubble);
    @(posedge clk); #1;
    set_fwd(1'b1, 5'd2, 32'd9, 1'b0, 5'd0, 32'h0);
    #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL lu_bubble got=%h exp=%h", got, e); end
    nvec++;
    if (bus.stall_out !== 1'b0) begin nerr++; $display("FAIL lu_stall_once got=%b exp=0", bus.stall_out); end
    exp_q.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,5'd5,32'd9,32'd9,32'd9));
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL lu_add_fwd got=%h exp=%h", got, e); end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_forward();
    obs_t got;
    obs_t e;
    drive(rtype(5'd6, 5'd3, 5'd7, 6'h20), 32'h55, 32'h66, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_fwd(1'b1, 5'd6, 32'd1, 1'b1, 5'd6, 32'd2); #1;
    nvec++;
    if ({bus.alu_a, bus.alu_b} !== {32'd1, 32'h66}) begin
      nerr++; $display("FAIL fwd_exmem_prio got a=%h b=%h exp a=1 b=66", bus.alu_a, bus.alu_b);
    end
    set_fwd(1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2); #1;
    nvec++;
    if (bus.alu_a !== 32'h55) begin nerr++; $display("FAIL fwd_rd0 got a=%h exp a=55", bus.alu_a); end
    set_fwd(1'b0, 5'd6, 32'd1, 1'b1, 5'd6, 32'd2); #1;
    nvec++;
    if (bus.alu_a !== 32'd2) begin nerr++; $display("FAIL fwd_memwb got a=%h exp a=2", bus.alu_a); end
    set_fwd(1'b1, 5'd6, 32'd1, 1'b1, 5'd3, 32'd2); #1;
    nvec++;
    if ({bus.alu_a, bus.alu_b, bus.store_data} !== {32'd1, 32'd2, 32'd2}) begin
      nerr++; $display("FAIL fwd_split got a=%h b=%h sd=%h exp 1/2/2", bus.alu_a, bus.alu_b, bus.store_data);
    end
    set_fwd(1'b1, 5'd3, 32'd8, 1'b1, 5'd3, 32'd2); #1;
    nvec++;
    if (bus.alu_b !== 32'd8) begin nerr++; $display("FAIL fwd_rt_prio got b=%h exp b=8", bus.alu_b); end
    drive(rtype(5'd0, 5'd0, 5'd7, 6'h20), 32'h11, 32'h22, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_fwd(1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2); #1;
    nvec++;
    if ({bus.alu_a, bus.alu_b} !== {32'h11, 32'h22}) begin
      nerr++; $display("FAIL fwd_reg0 got a=%h b=%h exp a=11 b=22", bus.alu_a, bus.alu_b);
    end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 1'b0, 1'b0);
    exp_q.push_back(bubble);
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL invalid_bubble got=%h exp=%h", got, e); end
  endtask

  task automatic test_flush();
    obs_t got;
    obs_t e;
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'd3, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(rtype(5'd2, 5'd2, 5'd5, 6'h20), 32'hAA, 32'hAA, 1'b1, 1'b1);
    exp_q.push_back(bubble);
    #1; nvec++;
    if (bus.stall_out !== 1'b0) begin nerr++; $display("FAIL flush_nostall got=%b exp=0", bus.stall_out); end
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL flush_bubble got=%h exp=%h", got, e); end
    bus.flush = 1'b0;
  endtask

  task automatic test_illegal();
    obs_t got;
    obs_t e;
    obs_t ill;
    ill = bubble;
    ill.ill = 1'b1;
    drive(32'hFC00_0000, 32'd1, 32'd1, 1'b1, 1'b0);
    exp_q.push_back(ill);
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL illegal_op got=%h exp=%h", got, e); end
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'd5, 32'd7, 1'b1, 1'b0);
    exp_q.push_back(ill);
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL illegal_funct got=%h exp=%h", got, e); end
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,5'd3,32'd5,32'd7,32'd7));
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL illegal_clear got=%h exp=%h", got, e); end
  endtask

  task automatic test_rst_midstream();
    obs_t got;
    obs_t e;
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'd3, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(rtype(5'd2, 5'd2, 5'd5, 6'h20), 32'hAA, 32'hAA, 1'b1, 1'b0);
    #1; nvec++;
    if (bus.stall_out !== 1'b1) begin nerr++; $display("FAIL rst_pre_stall got=%b exp=1", bus.stall_out); end
    rst = 1'b1;
    #1;
    got = cap(); nvec++;
    if (got !== bubble || bus.stall_out !== 1'b0 || bus.dest !== 5'd0 || bus.alu_a !== 32'h0) begin
      nerr++;
      $display("FAIL rst_async got=%h stall=%b dest=%0d alu_a=%h exp all 0",
               got, bus.stall_out, bus.dest, bus.alu_a);
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,5'd5,32'hAA,32'hAA,32'hAA));
    @(posedge clk); #1;
    got = cap(); e = exp_q.pop_front(); nvec++;
    if (got !== e) begin nerr++; $display("FAIL rst_first_edge got=%h exp=%h", got, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_decode();
    test_load_use();
    test_forward();
    test_flush();
    test_illegal();
    test_rst_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
